// File: rtl/sd_card_detect_ctrl.sv
// rtl/sd_card_detect_ctrl.sv - SD card-detect debounce, presence FSM and sticky interrupt status
module sd_card_detect_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cd_n_i,
  input  logic       enable,
  input  logic [1:0] int_mask,
  input  logic [1:0] int_ack,
  output logic       card_present,
  output logic       insert_evt,
  output logic       remove_evt,
  output logic [1:0] int_status,
  output logic       irq
);

  typedef enum logic [1:0] {ABSENT, DEB_IN, PRESENT, DEB_OUT} state_t;

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_prev;
  logic                   s_rise;
  logic                   s_fall;

  // Pin idles high (no card), so the chain resets to 1 to avoid a spurious insert.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync   <= '1;
      s_prev <= 1'b1;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], cd_n_i};
      s_prev <= s;
    end
  end

  assign s      = sync[SYNC_STAGES-1];
  assign s_rise = s & ~s_prev;
  assign s_fall = ~s & s_prev;

  // Inside DEB_IN the level has been 0 since entry, so a rise is exactly a bounce (mirror for DEB_OUT).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ABSENT;
      cnt          <= '0;
      card_present <= 1'b0;
      insert_evt   <= 1'b0;
      remove_evt   <= 1'b0;
      int_status   <= 2'b00;
    end else begin
      insert_evt <= 1'b0;
      remove_evt <= 1'b0;
      int_status <= int_status & ~int_ack;
      case (state)
        ABSENT: begin
          if (enable && !s) begin
            state <= DEB_IN;
            cnt   <= CNT_W'(1);
          end
        end
        DEB_IN: begin
          if (!enable || s_rise) begin
            state <= ABSENT;
            cnt   <= '0;
          end else if (cnt == DEB_MAX) begin
            state         <= PRESENT;
            cnt           <= '0;
            card_present  <= 1'b1;
            insert_evt    <= 1'b1;
            int_status[0] <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESENT: begin
          if (enable && s) begin
            state <= DEB_OUT;
            cnt   <= CNT_W'(1);
          end
        end
        DEB_OUT: begin
          if (!enable || s_fall) begin
            state <= PRESENT;
            cnt   <= '0;
          end else if (cnt == DEB_MAX) begin
            state         <= ABSENT;
            cnt           <= '0;
            card_present  <= 1'b0;
            remove_evt    <= 1'b1;
            int_status[1] <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ABSENT;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign irq = |(int_status & int_mask);

endmodule
